// File: rtl/slave_ctrl_pkg.sv
// slave_ctrl_pkg: shared definitions for the slave bus sequencer.
//   - state encoding localparams and the matching state enum
//   - is_onehot(): exactly-one-bit-set check used to validate a target select
package slave_ctrl_pkg;

    localparam int unsigned ST_IDLE = 0;
    localparam int unsigned ST_RDY  = 1;
    localparam int unsigned ST_ADDR = 2;
    localparam int unsigned ST_WAIT = 3;
    localparam int unsigned ST_DATA = 4;
    localparam int unsigned ST_RESP = 5;

    localparam int unsigned STATE_W = 3;

    // Widest select vector the one-hot helper accepts; callers zero-extend.
    localparam int unsigned MAX_SLV = 32;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = STATE_W'(ST_IDLE),
        S_RDY  = STATE_W'(ST_RDY),
        S_ADDR = STATE_W'(ST_ADDR),
        S_WAIT = STATE_W'(ST_WAIT),
        S_DATA = STATE_W'(ST_DATA),
        S_RESP = STATE_W'(ST_RESP)
    } state_t;

    // True when exactly one bit of v is set (clearing the lowest set bit leaves zero).
    function automatic logic is_onehot(input logic [MAX_SLV-1:0] v);
        return (v != '0) && ((v & (v - MAX_SLV'(1))) == '0);
    endfunction

endpackage

// File: rtl/slave_wait_cnt.sv
// slave_wait_cnt: loadable down-counter with zero flag.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val this cycle (has priority over dec)
//   load_val   value to load
//   dec        decrement by one; saturates at zero, never wraps
//   zero_c     combinational flag, count == 0
module slave_wait_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    // Count register: load wins, decrement stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero_c) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/slave_bus_ctrl.sv
// slave_bus_ctrl: slave-side bus sequencer serving NSLV channels from one FSM.
// Per transfer: RDY pulse, ADDR strobe, wait_cfg WAIT cycles, DATA strobe
// (write or read) held until the captured slave acks, then a RESP pulse.
// Optional macro: SLV_TIMEOUT_EN forces RESP with err=1 after TO_CYCLES
// DATA cycles without ack.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req, wr, sel,   master request, direction, one-hot target and wait count;
//   wait_cfg        sampled/captured only in IDLE
//   sl_ack          per-slave DATA completion (only captured bit, only in DATA)
//   busy            FSM not in IDLE
//   sl_rdy, sa,     ready pulse, address strobe, write strobe, read strobe,
//   sw, sr, slrsp   response pulse; only the captured bit is ever asserted
//   err             bad select pulse (and timeout during RESP when enabled)
module slave_bus_ctrl
    import slave_ctrl_pkg::*;
#(
    parameter int unsigned NSLV      = 4,
    parameter int unsigned WAIT_W    = 4,
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [NSLV-1:0]   sel,
    input  logic [WAIT_W-1:0] wait_cfg,
    input  logic [NSLV-1:0]   sl_ack,
    output logic              busy,
    output logic [NSLV-1:0]   sl_rdy,
    output logic [NSLV-1:0]   sa,
    output logic [NSLV-1:0]   sw,
    output logic [NSLV-1:0]   sr,
    output logic [NSLV-1:0]   slrsp,
    output logic              err
);

    localparam int unsigned TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    // Elaboration-time parameter sanity.
    if (NSLV < 1 || NSLV > MAX_SLV || WAIT_W < 1 || TO_CYCLES < 1 || TO_W > 32) begin : g_bad_param
        $error("slave_bus_ctrl: illegal parameter combination");
    end

    state_t              state;
    logic [NSLV-1:0]     sel_q;
    logic                wr_q;
    logic [WAIT_W-1:0]   wait_q;

    logic                wait_load;
    logic                wait_zero;
    logic                data_entry;
    logic                ack_hit;

    // Captured slave acked; other channels and other states are ignored.
    assign ack_hit = |(sl_ack & sel_q);

    // Edges that move the FSM into DATA.
    assign data_entry = ((state == S_ADDR) && (wait_q == '0)) ||
                        ((state == S_WAIT) && wait_zero);

    assign wait_load = (state == S_ADDR) && (wait_q != '0);

    // Loaded with wait_cfg-1 so that zero is seen in the last of wait_cfg WAIT cycles.
    slave_wait_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (WAIT_W'(wait_q - WAIT_W'(1))),
        .dec      (state == S_WAIT),
        .zero_c   (wait_zero)
    );

`ifdef SLV_TIMEOUT_EN
    logic to_zero;

    // Loaded with TO_CYCLES-1 on DATA entry; zero marks the TO_CYCLES-th DATA cycle.
    slave_wait_cnt #(.W(TO_W)) u_to_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (data_entry),
        .load_val (TO_W'(TO_CYCLES - 1)),
        .dec      (state == S_DATA),
        .zero_c   (to_zero)
    );
`endif

    // Control FSM; outputs are registered from the next state and captured select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sel_q  <= '0;
            wr_q   <= 1'b0;
            wait_q <= '0;
            busy   <= 1'b0;
            sl_rdy <= '0;
            sa     <= '0;
            sw     <= '0;
            sr     <= '0;
            slrsp  <= '0;
            err    <= 1'b0;
        end else begin
            sl_rdy <= '0;
            sa     <= '0;
            sw     <= '0;
            sr     <= '0;
            slrsp  <= '0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (is_onehot(MAX_SLV'(sel))) begin
                            sel_q  <= sel;
                            wr_q   <= wr;
                            wait_q <= wait_cfg;
                            state  <= S_RDY;
                            busy   <= 1'b1;
                            sl_rdy <= sel;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RDY: begin
                    state <= S_ADDR;
                    sa    <= sel_q;
                end
                S_ADDR, S_WAIT: begin
                    if (data_entry) begin
                        state <= S_DATA;
                        if (wr_q) sw <= sel_q;
                        else      sr <= sel_q;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_DATA: begin
                    if (ack_hit) begin
                        state <= S_RESP;
                        slrsp <= sel_q;
`ifdef SLV_TIMEOUT_EN
                    end else if (to_zero) begin
                        state <= S_RESP;
                        slrsp <= sel_q;
                        err   <= 1'b1;
`endif
                    end else if (wr_q) begin
                        sw <= sel_q;
                    end else begin
                        sr <= sel_q;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slave_bus_ctrl.sv
// tb_slave_bus_ctrl: directed + randomized bench for slave_bus_ctrl.
// Expected outputs come from a cycle-index timeline model of one transfer.
module tb_slave_bus_ctrl;

    localparam int unsigned NSLV = 4;
    localparam int unsigned WW   = 4;
    localparam int unsigned TO   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          wr;
    logic [3:0]    sel;
    logic [3:0]    wait_cfg;
    logic [3:0]    sl_ack;
    logic          busy;
    logic [3:0]    sl_rdy;
    logic [3:0]    sa;
    logic [3:0]    sw;
    logic [3:0]    sr;
    logic [3:0]    slrsp;
    logic          err;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;

    always #5 clk = ~clk;

    slave_bus_ctrl #(.NSLV(NSLV), .WAIT_W(WW), .TO_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr       (wr),
        .sel      (sel),
        .wait_cfg (wait_cfg),
        .sl_ack   (sl_ack),
        .busy     (busy),
        .sl_rdy   (sl_rdy),
        .sa       (sa),
        .sw       (sw),
        .sr       (sr),
        .slrsp    (slrsp),
        .err      (err)
    );

    // Expected {busy, err, sl_rdy, sa, sw, sr, slrsp} in cycle c after req is
    // sampled at edge 0: RDY=1, ADDR=2, WAIT=3..2+W, DATA=3+W..2+W+D, RESP=3+W+D.
    function automatic logic [21:0] model(input int c, input bit w, input logic [3:0] s,
                                          input int wt, input int d, input bit terr);
        int   resp_c;
        logic b;
        logic e;
        logic [3:0] rdy, a, wv, rv, rsp;
        resp_c = 3 + wt + d;
        b   = (c >= 1) && (c <= resp_c);
        e   = terr && (c == resp_c);
        rdy = (c == 1) ? s : 4'b0;
        a   = (c == 2) ? s : 4'b0;
        wv  = (w  && c >= 3 + wt && c < resp_c) ? s : 4'b0;
        rv  = (!w && c >= 3 + wt && c < resp_c) ? s : 4'b0;
        rsp = (c == resp_c) ? s : 4'b0;
        return {b, e, rdy, a, wv, rv, rsp};
    endfunction

    task automatic check(input string tag, input int c, input logic [21:0] exp);
        logic [21:0] obs;
        obs = {busy, err, sl_rdy, sa, sw, sr, slrsp};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
    endtask

    // One transfer with random noise on every ignored input. ack_after = number
    // of DATA cycles without ack before the ack cycle. abort_at>0 resets mid-run.
    // Ends at a negedge with the FSM in IDLE, so the next call tests back-to-back accept.
    task automatic do_txn(input string tag, input bit w, input logic [3:0] s, input int wt,
                          input int ack_after, input int abort_at);
        int  d;
        int  resp_c;
        int  data0;
        int  ack_c;
        bit  terr;
`ifdef SLV_TIMEOUT_EN
        if (ack_after + 1 > int'(TO)) begin d = int'(TO); terr = 1'b1; end
        else begin d = ack_after + 1; terr = 1'b0; end
`else
        d = ack_after + 1;
        terr = 1'b0;
`endif
        data0  = 3 + wt;
        resp_c = data0 + d;
        ack_c  = data0 + ack_after;
        req = 1'b1; wr = w; sel = s; wait_cfg = 4'(wt); sl_ack = 4'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= resp_c + 1; c++) begin
            req      = (c <= resp_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            wr       = 1'($urandom);
            sel      = 4'($urandom);
            wait_cfg = 4'($urandom);
            sl_ack   = 4'($urandom) & ~s;
            if (c == ack_c || c < data0 || c >= resp_c) begin
                if (c == ack_c || $urandom_range(0, 1) == 1) sl_ack = sl_ack | s;
            end
            @(negedge clk);
            check(tag, c, model(c, w, s, wt, d, terr));
            if (c == abort_at) begin
                #1 rst = 1'b1;
                #1 check({tag, "_rst"}, c, 22'b0);
                @(posedge clk); #1;
                rst = 1'b0; req = 1'b0; sl_ack = 4'b0;
                break;
            end
            if (c == resp_c + 1) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic bad_sel(input string tag, input logic [3:0] s);
        req = 1'b1; sel = s; wr = 1'($urandom); wait_cfg = 4'($urandom);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        check(tag, 1, 22'(1) << 20);
        @(posedge clk); #1;
        @(negedge clk);
        check(tag, 2, 22'b0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; sel = 4'b0; wait_cfg = 4'b0; sl_ack = 4'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 0, 22'b0);
        rst = 1'b0;

        do_txn("wr_s2_w0",   1'b1, 4'b0100, 0, 0, 0);
        do_txn("rd_s0_w3",   1'b0, 4'b0001, 3, 1, 0);
        bad_sel("bad_0011", 4'b0011);
        bad_sel("bad_0000", 4'b0000);
        do_txn("wr_s3_noise", 1'b1, 4'b1000, 2, 3, 0);
        do_txn("rst_mid",    1'b1, 4'b0100, 0, 1000, 5);
        do_txn("after_rst",  1'b0, 4'b0010, 1, 0, 0);
        do_txn("wait_max",   1'b1, 4'b0001, 15, 0, 0);
        do_txn("ack_at_to",  1'b0, 4'b0010, 1, int'(TO) - 1, 0);
        do_txn("no_ack",     1'b1, 4'b1000, 2, 1000, 110);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                logic [3:0] bs;
                bs = 4'($urandom);
                if (bs == 4'b0001 || bs == 4'b0010 || bs == 4'b0100 || bs == 4'b1000) bs = 4'b1111;
                bad_sel("rnd_bad", bs);
            end else begin
                do_txn("rnd", 1'($urandom), 4'(1 << $urandom_range(0, 3)),
                       ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 6)),
                       ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4)),
                       0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
